// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and defaults for the fetch unit.
// Provides word_t, the {pc, instr} buffer entry, depth and reset PC.
package ifetch_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } ibuf_t;

  localparam int    DEF_DEPTH    = 4;
  localparam word_t DEF_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: PC request, imem bus, decode handshake and flush.
// slave = fetch unit side, master = PC path / imem / decode side.
interface ifetch_if;
  import ifetch_pkg::*;

  word_t i_pc;
  logic  i_pc_valid;
  logic  o_pc_ready;
  logic  o_imem_req;
  word_t o_imem_addr;
  logic  i_imem_gnt;
  logic  i_imem_rvalid;
  word_t i_imem_rdata;
  logic  o_instr_valid;
  word_t o_instr;
  word_t o_instr_pc;
  logic  i_instr_ready;
  logic  i_flush;

  modport slave (
    input  i_pc, i_pc_valid, i_imem_gnt,
    input  i_imem_rvalid, i_imem_rdata,
    input  i_instr_ready, i_flush,
    output o_pc_ready, o_imem_req, o_imem_addr,
    output o_instr_valid, o_instr, o_instr_pc
  );

  modport master (
    output i_pc, i_pc_valid, i_imem_gnt,
    output i_imem_rvalid, i_imem_rdata,
    output i_instr_ready, i_flush,
    input  o_pc_ready, o_imem_req, o_imem_addr,
    input  o_instr_valid, o_instr, o_instr_pc
  );

endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous FIFO with clear, count and head output.
// Ports: clk/rst, clr, push/din, pop, head, count. Caller never overflows.
module ifetch_fifo #(
  parameter int           W       = 32,
  parameter int           DEPTH   = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [W-1:0]               i_din,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Entries are reset so the head shows RST_VAL out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= RST_VAL;
    end else if (i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (i_push) begin
        mem[wr_ptr] <= i_din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (i_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head  = mem[rd_ptr];
  assign o_count = count;

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: credit-limited pipelined fetch with flush/drop.
// Ports: i_clk, i_rst (sync, active-high), bus (ifetch_if.slave).
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int    DEPTH    = DEF_DEPTH,
  parameter word_t RESET_PC = DEF_RESET_PC
) (
  input  logic     i_clk,
  input  logic     i_rst,
  ifetch_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  // The PC queue holds one entry per in-flight request,
  // so its count is the outstanding counter.
  logic [CW-1:0] outstanding;
  logic [CW-1:0] buf_count;
  logic [CW-1:0] drop_cnt;
  logic [CW:0]   occ;
  logic          credit;
  logic          grant;
  logic          buf_push;
  logic          buf_pop;
  word_t         rsp_pc;
  ibuf_t         buf_head;

  assign occ    = {1'b0, outstanding} + {1'b0, buf_count};
  assign credit = (occ < (CW+1)'(DEPTH))
                & !bus.i_flush & !i_rst;

  assign bus.o_imem_req  = bus.i_pc_valid & credit;
  assign bus.o_imem_addr = {bus.i_pc[31:2], 2'b00};
  assign grant           = bus.o_imem_req & bus.i_imem_gnt;
  assign bus.o_pc_ready  = grant;

  assign buf_push = bus.i_imem_rvalid
                  & (drop_cnt == '0)
                  & !bus.i_flush;
  assign buf_pop  = bus.o_instr_valid
                  & bus.i_instr_ready
                  & !bus.i_flush;

  // A response landing in the flush cycle is already discarded,
  // so it is not counted among the ones still to drop.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      drop_cnt <= '0;
    else if (bus.i_flush)
      drop_cnt <= outstanding - CW'(bus.i_imem_rvalid);
    else if (bus.i_imem_rvalid && drop_cnt != '0)
      drop_cnt <= drop_cnt - 1'b1;
  end

  ifetch_fifo #(
    .W     (32),
    .DEPTH (DEPTH)
  ) u_pcq (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (1'b0),
    .i_push  (grant),
    .i_din   (bus.i_pc),
    .i_pop   (bus.i_imem_rvalid),
    .o_head  (rsp_pc),
    .o_count (outstanding)
  );

  ifetch_fifo #(
    .W       (64),
    .DEPTH   (DEPTH),
    .RST_VAL ({RESET_PC, 32'h0})
  ) u_ibuf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (bus.i_flush),
    .i_push  (buf_push),
    .i_din   ({rsp_pc, bus.i_imem_rdata}),
    .i_pop   (buf_pop),
    .o_head  (buf_head),
    .o_count (buf_count)
  );

  assign bus.o_instr_valid = (buf_count != '0);
  assign bus.o_instr       = buf_head.instr;
  assign bus.o_instr_pc    = buf_head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: queue-level reference model, memory responder,
// directed scenarios and randomized traffic.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  localparam int D = DEF_DEPTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_if bus();

  ifetch_unit dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct { word_t pc; bit drop; } fl_t;
  typedef struct { word_t pc; word_t ins; } bf_t;
  typedef struct { int due; word_t addr; } rq_t;

  fl_t   infl[$];
  bf_t   bq[$];
  rq_t   rq[$];
  word_t log_q[$];

  int cyc      = 0;
  int last_due = -1;
  int lat      = 1;
  int n_chk    = 0;
  int n_fail   = 0;
  int n_grant  = 0;
  bit last_grant = 1'b0;

  function automatic word_t mem_word(word_t a);
    return a ^ 32'h2048_0005;
  endfunction

  task automatic chk(string nm, word_t act, word_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // One clock: memory drives its response, outputs are compared
  // against the model at the falling edge, model advances.
  task automatic cycle();
    bit    exp_req;
    bit    pop;
    bit    keep;
    fl_t   f;
    word_t a;
    bus.i_imem_rvalid = 1'b0;
    bus.i_imem_rdata  = '0;
    if (!rst && rq.size() > 0 && rq[0].due <= cyc) begin
      bus.i_imem_rvalid = 1'b1;
      bus.i_imem_rdata  = mem_word(rq[0].addr);
    end
    @(negedge clk);
    exp_req = !rst && bus.i_pc_valid && !bus.i_flush
              && (infl.size() + bq.size() < D);
    a = {bus.i_pc[31:2], 2'b00};
    chk("imem_req", bus.o_imem_req, exp_req);
    chk("pc_ready", bus.o_pc_ready, exp_req && bus.i_imem_gnt);
    if (exp_req) chk("imem_addr", bus.o_imem_addr, a);
    chk("instr_valid", bus.o_instr_valid, bq.size() > 0);
    if (bq.size() > 0) begin
      chk("instr", bus.o_instr, bq[0].ins);
      chk("instr_pc", bus.o_instr_pc, bq[0].pc);
    end
    last_grant = exp_req && bus.i_imem_gnt;
    if (rst) begin
      infl.delete();
      bq.delete();
      rq.delete();
      last_due = -1;
    end else begin
      if (bus.o_instr_valid && bus.i_instr_ready && !bus.i_flush)
        log_q.push_back(bus.o_instr_pc);
      pop  = bq.size() > 0 && bus.i_instr_ready && !bus.i_flush;
      keep = 1'b0;
      if (bus.i_imem_rvalid && infl.size() > 0) begin
        f = infl.pop_front();
        void'(rq.pop_front());
        keep = !f.drop;
      end
      if (bus.i_flush) begin
        bq.delete();
        foreach (infl[i]) infl[i].drop = 1'b1;
      end else begin
        if (pop) void'(bq.pop_front());
        if (keep) bq.push_back(bf_t'{f.pc, bus.i_imem_rdata});
      end
      if (last_grant) begin
        infl.push_back(fl_t'{bus.i_pc, 1'b0});
        last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        rq.push_back(rq_t'{last_due, a});
        n_grant++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst               = 1'b1;
    bus.i_pc_valid    = 1'b1;
    bus.i_pc          = 32'h0040_0000;
    bus.i_imem_gnt    = 1'b1;
    bus.i_flush       = 1'b0;
    bus.i_instr_ready = 1'b0;
    bus.i_imem_rvalid = 1'b0;
    bus.i_imem_rdata  = '0;

    // Reset held two cycles with a pending request
    repeat (2) begin
      cycle();
      chk("rst_valid", bus.o_instr_valid, 0);
      chk("rst_req", bus.o_imem_req, 0);
    end
    chk("rst_instr", bus.o_instr, 32'h0);
    chk("rst_instr_pc", bus.o_instr_pc, 32'h0040_0000);
    rst = 1'b0;

    // Single fetch, L=1
    lat     = 1;
    n_grant = 0;
    cycle();
    chk("sf_grants", n_grant, 1);
    chk("sf_valid_early", bus.o_instr_valid, 0);
    bus.i_pc_valid = 1'b0;
    cycle();
    chk("sf_valid", bus.o_instr_valid, 1);
    chk("sf_instr", bus.o_instr, 32'h2008_0005);
    chk("sf_pc", bus.o_instr_pc, 32'h0040_0000);
    bus.i_instr_ready = 1'b1;
    cycle();
    chk("sf_drained", bus.o_instr_valid, 0);

    // Backpressure: credit stops issue after DEPTH grants
    bus.i_instr_ready = 1'b0;
    bus.i_pc          = 32'h0040_0000;
    bus.i_pc_valid    = 1'b1;
    n_grant           = 0;
    repeat (8) begin
      cycle();
      if (last_grant) bus.i_pc += 4;
    end
    chk("bp_grants", n_grant, 4);
    chk("bp_req_off", bus.o_imem_req, 0);
    bus.i_pc_valid    = 1'b0;
    bus.i_instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_head_pc", bus.o_instr_pc, 32'h0040_0000 + 4 * i);
      cycle();
    end
    chk("bp_empty", bus.o_instr_valid, 0);
    bus.i_pc_valid = 1'b1;
    n_grant        = 0;
    cycle();
    chk("bp_resume", n_grant, 1);
    bus.i_pc_valid = 1'b0;
    repeat (4) cycle();

    // Flush with two requests in flight, L=3
    lat = 3;
    log_q.delete();
    bus.i_pc       = 32'h0040_0000;
    bus.i_pc_valid = 1'b1;
    cycle();
    bus.i_pc = 32'h0040_0004;
    cycle();
    bus.i_flush = 1'b1;
    cycle();
    bus.i_flush = 1'b0;
    bus.i_pc    = 32'h0040_0020;
    cycle();
    bus.i_pc_valid = 1'b0;
    repeat (8) cycle();
    chk("fl_count", log_q.size(), 1);
    if (log_q.size() > 0) chk("fl_pc", log_q[0], 32'h0040_0020);

    // Flush coincident with rvalid and a pop, buffer at 2
    lat = 2;
    log_q.delete();
    bus.i_instr_ready = 1'b0;
    bus.i_pc          = 32'h0040_0000;
    bus.i_pc_valid    = 1'b1;
    repeat (4) begin
      cycle();
      if (last_grant) bus.i_pc += 4;
    end
    chk("fc_model_buf", bq.size(), 2);
    chk("fc_valid", bus.o_instr_valid, 1);
    chk("fc_head", bus.o_instr_pc, 32'h0040_0000);
    bus.i_pc_valid    = 1'b0;
    bus.i_flush       = 1'b1;
    bus.i_instr_ready = 1'b1;
    cycle();
    bus.i_flush = 1'b0;
    chk("fc_empty", bus.o_instr_valid, 0);
    chk("fc_model_infl", infl.size(), 1);
    repeat (5) cycle();
    chk("fc_none", log_q.size(), 0);

    // Steady state, L=2: one instruction per cycle
    lat = 2;
    log_q.delete();
    bus.i_instr_ready = 1'b1;
    bus.i_pc          = 32'h0040_1000;
    bus.i_pc_valid    = 1'b1;
    n_grant           = 0;
    repeat (20) begin
      cycle();
      if (last_grant) bus.i_pc += 4;
    end
    chk("ss_grants", n_grant, 20);
    chk("ss_count", log_q.size(), 17);
    foreach (log_q[i])
      chk("ss_seq", log_q[i], 32'h0040_1000 + 4 * i);
    bus.i_pc_valid = 1'b0;
    repeat (4) cycle();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst               = ($urandom_range(0, 199) == 0);
      bus.i_pc_valid    = ($urandom_range(0, 9) < 7);
      bus.i_imem_gnt    = ($urandom_range(0, 9) < 7);
      bus.i_instr_ready = ($urandom_range(0, 9) < 7);
      bus.i_flush       = ($urandom_range(0, 24) == 0);
      lat               = $urandom_range(1, 4);
      if (last_grant) begin
        if ($urandom_range(0, 7) == 0)
          bus.i_pc = $urandom & 32'hFFFF_FFFC;
        else
          bus.i_pc += 4;
      end
      cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit sitting between the program counter register and instruction memory, on the consuming end of the PC address stream. Accepts fetch addresses from the PC/next-PC path, issues pipelined read requests to instruction memory, tracks in-flight requests, and buffers returned instruction words, each paired with its PC, for the decode stage. Supports a branch/jump flush that discards buffered and in-flight fetches.

## Interface
- DEPTH, 4, max in-flight requests plus buffered instructions; power of two, ≥2
- RESET_PC, 32'h0040_0000, value of o_instr_pc out of reset
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_pc  in  32  fetch address from PC path
- i_pc_valid  in  1  i_pc holds a fetch request
- o_pc_ready  out  1  request accepted this cycle
- o_imem_req  out  1  read request to instruction memory
- o_imem_addr  out  32  word address: {i_pc[31:2], 2'b00}
- i_imem_gnt  in  1  memory accepts the request this cycle
- i_imem_rvalid  in  1  read data valid; responses in request order, no backpressure
- i_imem_rdata  in  32  instruction word
- o_instr_valid  out  1  buffered instruction available
- o_instr  out  32  instruction word at buffer head
- o_instr_pc  out  32  PC of o_instr
- i_instr_ready  in  1  decode consumes head when o_instr_valid
- i_flush  in  1  redirect: discard everything fetched or in flight

## Operation
- Credit: occ = outstanding + buf_count (registered values only). Issue allowed when occ < DEPTH and !i_flush.
- o_imem_req = i_pc_valid & credit; o_pc_ready = o_imem_req & i_imem_gnt (combinational). Accepted request pushes i_pc onto the PC queue and increments outstanding.
- i_imem_rvalid: pop PC queue, decrement outstanding; if drop_cnt > 0, discard the response and decrement drop_cnt, otherwise push {pc, rdata} into the instruction buffer.
- Credit rule guarantees the buffer never overflows; rvalid is never refused.
- o_instr_valid = buffer not empty; o_instr/o_instr_pc = head entry. Pop on o_instr_valid & i_instr_ready.
- Flush: buffer cleared; drop_cnt <= outstanding minus any response arriving in the flush cycle; no request issued in the flush cycle; a pop in the flush cycle has no further effect.
- Simultaneous grant + rvalid: outstanding unchanged, PC queue push and pop both occur. Simultaneous push + pop on the buffer: count unchanged.
- Reset: outstanding, drop_cnt, buf_count, and queue pointers = 0; o_instr_valid = 0; o_instr = 32'h0; o_instr_pc = RESET_PC. Instruction memory shares i_rst, so no responses arrive for pre-reset requests.
- Counter width: $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.

## Timing
- Grant in cycle t, rvalid in cycle t+L (L ≥ 1): o_instr_valid first asserted in cycle t+L+1.
- o_imem_req responds combinationally to i_pc_valid and i_flush. No combinational path from i_instr_ready or i_imem_rvalid to o_imem_req.
- o_instr_valid deasserts in the cycle after i_flush; a request may issue in the cycle after i_flush.
- Sustained throughput of 1 instr/cycle requires DEPTH ≥ L+2.

## Structure
- Shared package (ifetch_pkg): RESET_PC constant, word_t (32-bit), DEPTH default.
- One sub-module, ifetch_fifo: parameterised-width synchronous FIFO with clear, count, and head outputs. Instantiated twice: the PC queue (32-bit) and the instruction buffer (64-bit {pc, instr}).

## Test plan
- Reset: hold i_rst 2 cycles with i_pc_valid=1 -> o_instr_valid=0, o_instr=0, o_instr_pc=0x00400000, o_imem_req=0 during reset.
- Single fetch, L=1: i_pc=0x00400000 granted in cycle 0, rdata 0x20080005 in cycle 1 -> o_instr_valid in cycle 2, o_instr=0x20080005, o_instr_pc=0x00400000.
- Backpressure: i_instr_ready=0, sequential PCs from 0x00400000, L=1 -> exactly 4 grants, then o_imem_req=0. Raising ready drains 0x00400000..0x0040000C in order and fetching resumes.
- Flush in flight, L=3: grant 0x00400000 and 0x00400004, i_flush next cycle, then grant 0x00400020 -> both old responses dropped; only 0x00400020 is presented.
- Flush coincident with rvalid and a pop, buffer holding 2 entries -> buffer empty next cycle, drop_cnt = outstanding−1, no stale instruction ever valid.
- Grant and rvalid in the same cycle at steady state with L=2 -> outstanding constant, one instruction per cycle with DEPTH=4, PCs strictly sequential.
